pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline register, single entry or skid x2  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int          WIDTH    = 32,
  parameter int          LANES    = 4,
  parameter int          CTRL_W   = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          SKID     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*WIDTH-1:0]  in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [31:0]             in_pc,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*WIDTH-1:0]  out_data,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [31:0]             out_pc,
  output logic [1:0]              occupancy
);
  localparam int c_DW = LANES * WIDTH;

  // Encoding doubles as the held-word count; FULL of the single-entry build is c_ONE.
  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              w_valid;
  logic              w_accept;
  logic              w_dequeue;
  logic              w_load_main;
  logic              w_load_skid;
  logic              w_main_from_skid;
  logic [c_DW-1:0]   r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [31:0]       r_main_pc;
  logic [c_DW-1:0]   w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [31:0]       w_skid_pc;

  assign w_valid          = (r_state != c_EMPTY);
  assign w_accept         = in_valid && in_ready && !stall && !flush;
  assign w_dequeue        = w_valid && out_ready && !stall && !flush;
  assign w_load_main      = w_accept && ((r_state == c_EMPTY) || w_dequeue);
  assign w_load_skid      = w_accept && (r_state == c_ONE) && !w_dequeue;
  assign w_main_from_skid = (r_state == c_TWO) && w_dequeue;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = c_EMPTY;
    end else begin
      case (r_state)
        c_EMPTY: if (w_accept) w_next_state = c_ONE;
        c_ONE: begin
          if (w_accept && !w_dequeue)      w_next_state = (SKID != 0) ? c_TWO : c_ONE;
          else if (!w_accept && w_dequeue) w_next_state = c_EMPTY;
        end
        c_TWO:   if (w_dequeue) w_next_state = c_ONE;
        default: w_next_state = c_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = w_valid;
    occupancy = r_state;
    out_data  = '0;
    out_ctrl  = '0;
    out_pc    = PC_RESET;
    if (w_valid) begin
      out_data = r_main_data;
      out_ctrl = r_main_ctrl;
      out_pc   = r_main_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_main_pc   <= PC_RESET;
    end else if (w_main_from_skid) begin
      r_main_data <= w_skid_data;
      r_main_ctrl <= w_skid_ctrl;
      r_main_pc   <= w_skid_pc;
    end else if (w_load_main) begin
      r_main_data <= in_data;
      r_main_ctrl <= in_ctrl;
      r_main_pc   <= in_pc;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [c_DW-1:0]   r_skid_data;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [31:0]       r_skid_pc;
      logic              r_in_ready;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_skid_data <= '0;
          r_skid_ctrl <= '0;
          r_skid_pc   <= PC_RESET;
          r_in_ready  <= 1'b1;
        end else begin
          if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_skid_pc   <= in_pc;
          end
          r_in_ready <= (w_next_state != c_TWO);
        end
      end

      assign w_skid_data = r_skid_data;
      assign w_skid_ctrl = r_skid_ctrl;
      assign w_skid_pc   = r_skid_pc;
      assign in_ready    = r_in_ready && !stall && reset;
    end else begin : g_single
      assign w_skid_data = '0;
      assign w_skid_ctrl = '0;
      assign w_skid_pc   = '0;
      // Full stage may take a word only on the edge that also drains it.
      assign in_ready    = (!w_valid || out_ready) && !stall && reset;
    end
  endgenerate

endmodule
`default_nettype wire
